// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write queue.
//   addr_w(d) : register index width for a file of d registers
//   entry_t   : one queued write {addr, data}, sized for the default
//               20 x 32-bit register file (REG_D / REG_W).
// The top level's D and W parameters default to REG_D / REG_W. They
// must stay equal to these, because entry_t is sized from the package.
package regfile_pkg;

  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int REG_D  = 20;
  localparam int REG_W  = 32;
  localparam int REG_AW = addr_w(REG_D);

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_W-1:0]  data;
  } entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Request and issue channels of the write queue.
//   req_valid/req_ready/req_addr/req_data : incoming write requests
//   wr_stall                              : register array busy
//   dec_sel/dec_en/wr_data                : registered issue to decoder/array
// The master is the requester/array side. The slave is the queue.
interface regfile_write_queue_if
  import regfile_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int W  = REG_W
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data;
  logic          wr_stall;
  logic [AW-1:0] dec_sel;
  logic          dec_en;
  logic [W-1:0]  wr_data;

  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, dec_sel, dec_en, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, dec_sel, dec_en, wr_data
  );
endinterface

// File: rtl/regfile_wq_fifo.sv
// Circular FIFO holding pending register writes.
//   clk, rst       : clock, asynchronous active-high reset
//   push, wdata    : enqueue wdata (ignored when full)
//   pop, head      : dequeue; head is the oldest entry
//   full, empty    : occupancy flags
//   count          : occupied entries (0..DEPTH)
//   entries, valid : all entries in age order (index 0 = oldest) with a
//                    valid mask, for the forwarding search
module regfile_wq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output entry_t                     entries [DEPTH],
  output logic [DEPTH-1:0]           valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Its contents only matter where
  // count marks them valid, so resetting it would add fanout and buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Re-index the storage relative to the read pointer so the consumer
  // sees entries oldest-first, without having to know the pointers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Register-file write queue: buffers write requests and issues one per
// cycle to the write-select decoder. It forwards data that is not yet
// committed, so readers never see stale values.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : request channel plus registered issue outputs (slave)
//   rd_addr   : read index checked against pending writes
//   fwd_hit   : rd_addr matches a queued or issuing write
//   fwd_data  : data of the youngest matching write, 0 on miss
//   drop      : one-cycle pulse for an accepted out-of-range request
//   count     : occupied queue entries
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int D     = REG_D,
  parameter int W     = REG_W,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_write_queue_if.slave         bus,
  input  logic [addr_w(D)-1:0]         rd_addr,
  output logic                         fwd_hit,
  output logic [W-1:0]                 fwd_data,
  output logic                         drop,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = addr_w(D);

  entry_t           head;
  entry_t           ents [DEPTH];
  logic [DEPTH-1:0] ents_valid;
  logic             full;
  logic             empty;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;
  entry_t           push_entry;

  // Ready depends only on registered occupancy, never on req_valid.
  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && bus.req_ready;
  // The extra bit keeps the compare correct when D is a power of two.
  assign in_range      = {1'b0, bus.req_addr} < (AW + 1)'(D);
  assign push          = accept && in_range;
  assign pop           = !bus.wr_stall && !empty;
  assign push_entry    = '{addr: bus.req_addr, data: bus.req_data};

  regfile_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .entries (ents),
    .valid   (ents_valid)
  );

  // The issue register holds sel/data while idle. dec_en is high for
  // exactly one cycle per popped write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dec_en  <= 1'b0;
      bus.dec_sel <= '0;
      bus.wr_data <= '0;
      drop        <= 1'b0;
    end else begin
      drop <= accept && !in_range;
      if (pop) begin
        bus.dec_en  <= 1'b1;
        bus.dec_sel <= head.addr;
        bus.wr_data <= head.data;
      end else begin
        bus.dec_en  <= 1'b0;
      end
    end
  end

  // Priority mux: the search starts at the oldest source (the issuing
  // write) and walks toward the tail, so a later match overrides an
  // earlier one. The youngest matching write therefore wins.
  // NOTE: both outputs get a default before any branch, so no latch is inferred.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (bus.dec_en && bus.dec_sel == rd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ents_valid[i] && ents[i].addr == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = ents[i].data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized and directed bench for regfile_write_queue. A queue-based
// reference model tracks pending writes, the issue register and the drop pulse.
module tb_regfile_write_queue;
  localparam int D     = 20;
  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct {
    int          addr;
    logic [W-1:0] data;
  } m_ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic          fwd_hit;
  logic [W-1:0]  fwd_data;
  logic          drop;
  logic [CW-1:0] count;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  m_ent_t       mq[$];
  logic         m_en;
  int           m_sel;
  logic [W-1:0] m_data;
  logic         m_drop;

  regfile_write_queue_if #(.AW(AW), .W(W)) bus ();

  regfile_write_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rd_addr  (rd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .drop     (drop),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_en   = 1'b0;
    m_sel  = 0;
    m_data = '0;
    m_drop = 1'b0;
  endtask

  // The youngest matching write wins: the issue register is the oldest
  // source, then the queue from head to tail.
  task automatic model_fwd(input int ra, output logic hit, output logic [W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (m_en && m_sel == ra) begin hit = 1'b1; data = m_data; end
    foreach (mq[i]) if (mq[i].addr == ra) begin hit = 1'b1; data = mq[i].data; end
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  // The combinational outputs are compared before the rising edge and the
  // registered outputs after it.
  task automatic cycle(input logic v, input int a, input logic [W-1:0] d,
                       input logic st, input int ra);
    logic         e_hit;
    logic [W-1:0] e_fd;
    logic         acc;
    m_ent_t       h;
    bus.req_valid = v;
    bus.req_addr  = AW'(a);
    bus.req_data  = d;
    bus.wr_stall  = st;
    rd_addr       = AW'(ra);
    #1;
    model_fwd(ra, e_hit, e_fd);
    vectors++;
    if (bus.req_ready !== (mq.size() != DEPTH)) begin
      errors++; $display("FAIL req_ready: got %0b want %0b", bus.req_ready, mq.size() != DEPTH);
    end
    vectors++;
    if (fwd_hit !== e_hit || fwd_data !== e_fd) begin
      errors++; $display("FAIL fwd rd=%0d: got %0b/%0h want %0b/%0h", ra, fwd_hit, fwd_data, e_hit, e_fd);
    end
    @(posedge clk);
    acc = v && (mq.size() != DEPTH);
    if (!st && mq.size() != 0) begin
      h = mq.pop_front(); m_en = 1'b1; m_sel = h.addr; m_data = h.data;
    end else begin
      m_en = 1'b0;
    end
    m_drop = acc && (a >= D);
    if (acc && a < D) mq.push_back('{addr: a, data: d});
    @(negedge clk);
    vectors++;
    if (bus.dec_en !== m_en || bus.dec_sel !== AW'(m_sel) || bus.wr_data !== m_data) begin
      errors++; $display("FAIL issue: got en=%0b sel=%0d data=%0h want en=%0b sel=%0d data=%0h",
                         bus.dec_en, bus.dec_sel, bus.wr_data, m_en, m_sel, m_data);
    end
    vectors++;
    if (drop !== m_drop || count !== CW'(mq.size())) begin
      errors++; $display("FAIL drop/count: got %0b/%0d want %0b/%0d", drop, count, m_drop, mq.size());
    end
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, st, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.wr_stall = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.dec_en !== 1'b0 || bus.dec_sel !== '0 || bus.wr_data !== '0 || drop !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL reset_state: got en=%0b sel=%0d data=%0h drop=%0b count=%0d want all 0",
                         bus.dec_en, bus.dec_sel, bus.wr_data, drop, count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    cycle(1'b1, 3, 32'hA5, 1'b0, 3);
    vectors++;
    if (count !== 3'd1 || bus.dec_en !== 1'b0) begin
      errors++; $display("FAIL single_accept: got count=%0d en=%0b want 1/0", count, bus.dec_en);
    end
    idle(1, 1'b0);
    vectors++;
    if (bus.dec_en !== 1'b1 || bus.dec_sel !== 5'd3 || bus.wr_data !== 32'hA5) begin
      errors++; $display("FAIL single_issue: got %0b/%0d/%0h want 1/3/a5", bus.dec_en, bus.dec_sel, bus.wr_data);
    end
    idle(1, 1'b0);
    vectors++;
    if (bus.dec_en !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL single_done: got en=%0b count=%0d want 0/0", bus.dec_en, count);
    end
  endtask

  task automatic test_stall();
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 32'h100 + i, 1'b1, 0);
    vectors++;
    if (bus.req_ready !== 1'b0 || count !== 3'd4 || bus.dec_en !== 1'b0) begin
      errors++; $display("FAIL stall_full: got rdy=%0b count=%0d en=%0b want 0/4/0", bus.req_ready, count, bus.dec_en);
    end
    for (int i = 1; i <= 4; i++) begin
      idle(1, 1'b0);
      vectors++;
      if (bus.dec_en !== 1'b1 || bus.dec_sel !== AW'(i)) begin
        errors++; $display("FAIL stall_drain: got en=%0b sel=%0d want 1/%0d", bus.dec_en, bus.dec_sel, i);
      end
    end
    idle(1, 1'b0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) cycle(1'b1, 10 + i, 32'h200 + i, 1'b1, 0);
    cycle(1'b1, 7, 32'h777, 1'b0, 7);
    vectors++;
    if (count !== 3'd3 || bus.dec_sel !== 5'd10) begin
      errors++; $display("FAIL full_no_push: got count=%0d sel=%0d want 3/10", count, bus.dec_sel);
    end
    idle(4, 1'b0);
    cycle(1'b1, 1, 32'h301, 1'b1, 0);
    cycle(1'b1, 2, 32'h302, 1'b1, 0);
    cycle(1'b1, 9, 32'h309, 1'b0, 9);
    vectors++;
    if (count !== 3'd2 || bus.dec_sel !== 5'd1) begin
      errors++; $display("FAIL push_pop: got count=%0d sel=%0d want 2/1", count, bus.dec_sel);
    end
    idle(1, 1'b0);
    vectors++;
    if (bus.dec_sel !== 5'd2) begin
      errors++; $display("FAIL push_pop_order0: got sel=%0d want 2", bus.dec_sel);
    end
    idle(1, 1'b0);
    vectors++;
    if (bus.dec_sel !== 5'd9 || bus.wr_data !== 32'h309) begin
      errors++; $display("FAIL push_pop_order1: got %0d/%0h want 9/309", bus.dec_sel, bus.wr_data);
    end
    idle(1, 1'b0);
  endtask

  task automatic test_forward();
    cycle(1'b1, 5, 32'h11, 1'b1, 0);
    cycle(1'b1, 5, 32'h22, 1'b1, 0);
    rd_addr = 5'd5;
    #1;
    vectors++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
      errors++; $display("FAIL fwd_youngest: got %0b/%0h want 1/22", fwd_hit, fwd_data);
    end
    rd_addr = 5'd6;
    #1;
    vectors++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_miss: got %0b/%0h want 0/0", fwd_hit, fwd_data);
    end
    idle(4, 1'b0);
  endtask

  task automatic test_drop();
    cycle(1'b1, 25, 32'hDEAD, 1'b0, 0);
    vectors++;
    if (drop !== 1'b1 || count !== 3'd0 || bus.dec_en !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: got drop=%0b count=%0d en=%0b want 1/0/0", drop, count, bus.dec_en);
    end
    idle(1, 1'b0);
    vectors++;
    if (drop !== 1'b0 || bus.dec_en !== 1'b0) begin
      errors++; $display("FAIL drop_clear: got drop=%0b en=%0b want 0/0", drop, bus.dec_en);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 12 + i, 32'h400 + i, 1'b1, 0);
    idle(1, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.dec_en !== 1'b0 || bus.dec_sel !== '0 || bus.wr_data !== '0 || count !== '0) begin
      errors++; $display("FAIL reset_mid: got en=%0b sel=%0d data=%0h count=%0d want 0/0/0/0",
                         bus.dec_en, bus.dec_sel, bus.wr_data, count);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      vectors++;
      if (bus.dec_en !== 1'b0) begin
        errors++; $display("FAIL reset_no_issue: got en=%0b want 0", bus.dec_en);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) != 0, $urandom_range(0, 23), $urandom,
            ($urandom % 10) < 4, $urandom_range(0, 31));
    idle(6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full_push_pop();
    test_forward();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
